// File: rtl/cam_mmio_pkg.sv
// Purpose: shared address map, register bit positions and region decode for cam_mmio_bridge.
// Latency: n/a (constants, types and a pure combinational helper function).
// Backpressure: n/a.
package cam_mmio_pkg;

    // Memory map (byte addresses; addr[1:0] are ignored by the decoder)
    localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
    localparam logic [31:0] STATUS_ADDR = 32'h0001_0000;
    localparam logic [31:0] PIXEL_ADDR  = 32'h0001_0004;
    localparam logic [31:0] CTRL_ADDR   = 32'h0001_0008;

    // CTRL register bits
    localparam int CTRL_CAP_EN = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_FLUSH  = 2;

    // STATUS register fields
    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_CNT_LSB   = 3;
    localparam int ST_CNT_W     = 5;
    localparam int ST_FRAME_LSB = 16;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_STATUS,
        REG_PIXEL,
        REG_CTRL,
        REG_NONE
    } region_e;

    // Word-aligned decode; ram_bytes is the size of the RAM window in bytes.
    function automatic region_e decode_region(input logic [31:0] a,
                                              input logic [31:0] ram_bytes);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        if ((wa - RAM_BASE) < ram_bytes) return REG_RAM;
        else if (wa == STATUS_ADDR)      return REG_STATUS;
        else if (wa == PIXEL_ADDR)       return REG_PIXEL;
        else if (wa == CTRL_ADDR)        return REG_CTRL;
        else                             return REG_NONE;
    endfunction

endpackage

// File: rtl/cam_mmio_bridge_word_fifo.sv
// Purpose: synchronous word FIFO with flush; head word is visible combinationally.
// Latency: a push is visible at o_head/o_count one cycle after the accepting edge.
// Backpressure: pushes while full and pops while empty are ignored; flush wins over push/pop.
//
// Ports:
//   i_clk, i_rst             clock, async active-high reset
//   i_push, i_push_dat       write a word (ignored when full)
//   i_pop                    discard head word (ignored when empty)
//   i_flush                  empty the FIFO on this edge
//   o_head, o_count          head word, current occupancy (0..DEPTH)
//   o_full, o_empty          occupancy flags
module word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_head,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push & ~o_full & ~i_flush;
    assign w_do_pop  = i_pop  & ~o_empty & ~i_flush;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            // push+pop together leaves the occupancy unchanged
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_dat;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/cam_mmio_bridge.sv
// Purpose: core data-side bridge: word RAM plus memory-mapped camera capture (4 pixels/word FIFO).
// Latency: rdata is combinational from addr; stores/pops/pixel pushes take effect on the next edge; irq lags one cycle.
// Backpressure: pix_ready = cap_en & ~full; pixels offered while enabled and full are dropped and flagged sticky overflow.
//
// Ports:
//   clk, reset                       clock, async active-high reset
//   addr, wdata, we, rdata           core load/store port (rdata combinational)
//   pix_valid, pix_data, pix_ready   camera pixel stream
//   frame_start                      one-cycle frame marker (realigns packer, counts frames)
//   irq                              registered data-available interrupt
module cam_mmio_bridge
    import cam_mmio_pkg::*;
#(
    parameter int RAM_WORDS  = 256,
    parameter int FIFO_DEPTH = 16,
    parameter int PIXEL_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    input  logic               we,
    output logic [31:0]        rdata,
    input  logic               pix_valid,
    input  logic [PIXEL_W-1:0] pix_data,
    output logic               pix_ready,
    input  logic               frame_start,
    output logic               irq
);

    localparam int          RAM_AW    = $clog2(RAM_WORDS);
    localparam int          FCW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

    // ---------------- decode ----------------
    region_e w_region;
    logic    w_ram_we;
    logic    w_pop;
    logic    w_ctrl_we;
    logic    w_flush;

    assign w_region  = decode_region(addr, RAM_BYTES);
    assign w_ram_we  = we & (w_region == REG_RAM);
    assign w_pop     = we & (w_region == REG_PIXEL);
    assign w_ctrl_we = we & (w_region == REG_CTRL);
    assign w_flush   = w_ctrl_we & wdata[CTRL_FLUSH];

    // ---------------- data RAM ----------------
    logic [31:0]       r_ram [RAM_WORDS];
    logic [RAM_AW-1:0] w_ram_idx;

    assign w_ram_idx = addr[RAM_AW+1:2];

    always_ff @(posedge clk) begin
        if (w_ram_we) r_ram[w_ram_idx] <= wdata;
    end

    // ---------------- control / status registers ----------------
    logic        r_cap_en;
    logic        r_irq_en;
    logic        r_ovf;
    logic [15:0] r_frame_cnt;
    logic        r_irq;

    // ---------------- FIFO ----------------
    logic [31:0]    w_head;
    logic [FCW-1:0] w_count;
    logic           w_full;
    logic           w_empty;
    logic           w_push;

    // ---------------- packer ----------------
    logic [1:0]  r_pk_idx;
    logic [31:0] r_pk_word;
    logic [1:0]  w_idx_eff;
    logic [31:0] w_pk_next;
    logic        w_accept;
    logic        w_drop;

    assign pix_ready = r_cap_en & ~w_full;
    assign w_accept  = pix_valid & pix_ready;
    assign w_drop    = pix_valid & r_cap_en & w_full;

    // A frame marker restarts the word, so a pixel arriving with it lands in byte 0.
    assign w_idx_eff = frame_start ? 2'd0 : r_pk_idx;
    assign w_push    = w_accept & (w_idx_eff == 2'd3);

    always_comb begin
        w_pk_next = r_pk_word;
        w_pk_next[int'(w_idx_eff) * PIXEL_W +: PIXEL_W] = pix_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pk_idx  <= 2'd0;
            r_pk_word <= '0;
        end else if (w_flush) begin
            r_pk_idx  <= 2'd0;
            r_pk_word <= '0;
        end else if (w_accept) begin
            r_pk_idx  <= w_idx_eff + 2'd1;   // 3 -> 0 as the full word is pushed
            r_pk_word <= w_pk_next;
        end else if (frame_start) begin
            r_pk_idx  <= 2'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cap_en    <= 1'b0;
            r_irq_en    <= 1'b0;
            r_ovf       <= 1'b0;
            r_frame_cnt <= '0;
            r_irq       <= 1'b0;
        end else begin
            if (w_ctrl_we) begin
                r_cap_en <= wdata[CTRL_CAP_EN];
                r_irq_en <= wdata[CTRL_IRQ_EN];
            end
            if (w_flush)     r_ovf <= 1'b0;
            else if (w_drop) r_ovf <= 1'b1;
            if (frame_start) r_frame_cnt <= r_frame_cnt + 16'd1;
            r_irq <= r_irq_en & ~w_empty;
        end
    end

    assign irq = r_irq;

    word_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (clk),
        .i_rst      (reset),
        .i_push     (w_push),
        .i_push_dat (w_pk_next),
        .i_pop      (w_pop),
        .i_flush    (w_flush),
        .o_head     (w_head),
        .o_count    (w_count),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    // ---------------- read mux ----------------
    logic [31:0] w_cnt_ext;
    logic [31:0] w_status;

    assign w_cnt_ext = 32'(w_count);

    always_comb begin
        w_status = '0;
        w_status[ST_EMPTY] = w_empty;
        w_status[ST_FULL]  = w_full;
        w_status[ST_OVF]   = r_ovf;
        w_status[ST_CNT_LSB +: ST_CNT_W] = w_cnt_ext[ST_CNT_W-1:0];
        w_status[ST_FRAME_LSB +: 16]     = r_frame_cnt;
    end

    always_comb begin
        rdata = '0;
        case (w_region)
            REG_RAM:    rdata = r_ram[w_ram_idx];
            REG_STATUS: rdata = w_status;
            REG_PIXEL:  rdata = w_empty ? 32'd0 : w_head;
            REG_CTRL:   rdata = {30'd0, r_irq_en, r_cap_en};
            default:    rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_cam_mmio_bridge.sv
module tb_cam_mmio_bridge;
    import cam_mmio_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        pix_ready;
    logic        frame_start;
    logic        irq;

    always #5 clk = ~clk;

    cam_mmio_bridge #(
        .RAM_WORDS  (256),
        .FIFO_DEPTH (16),
        .PIXEL_W    (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .addr        (addr),
        .wdata       (wdata),
        .we          (we),
        .rdata       (rdata),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .pix_ready   (pix_ready),
        .frame_start (frame_start),
        .irq         (irq)
    );

    // Scoreboard: kind 0 = rdata, 1 = pix_ready, 2 = irq
    string       nm_q [$];
    int          kd_q [$];
    logic [31:0] ex_q [$];
    logic        chk_vld = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    string       m_nm;
    int          m_kd;
    logic [31:0] m_ex;
    logic [31:0] m_act;

    always @(negedge clk) begin
        if (chk_vld) begin
            while (nm_q.size() > 0) begin
                m_nm = nm_q.pop_front();
                m_kd = kd_q.pop_front();
                m_ex = ex_q.pop_front();
                case (m_kd)
                    0:       m_act = rdata;
                    1:       m_act = {31'd0, pix_ready};
                    default: m_act = {31'd0, irq};
                endcase
                n_cmp++;
                if (m_act !== m_ex) begin
                    n_bad++;
                    $display("FAIL %s: actual 0x%08h required 0x%08h", m_nm, m_act, m_ex);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        chk_vld = 1'b0;
    endtask

    task automatic expect_sig(input string nm, input int kd, input logic [31:0] ex);
        nm_q.push_back(nm);
        kd_q.push_back(kd);
        ex_q.push_back(ex);
        chk_vld = 1'b1;
    endtask

    task automatic expect_rd(input string nm, input logic [31:0] a, input logic [31:0] ex);
        addr = a;
        we   = 1'b0;
        expect_sig(nm, 0, ex);
        cyc();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        cyc();
        we    = 1'b0;
    endtask

    task automatic send_pix(input logic [7:0] p);
        pix_valid = 1'b1;
        pix_data  = p;
        cyc();
        pix_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; addr = '0; wdata = '0; we = 1'b0;
        pix_valid = 1'b0; pix_data = '0; frame_start = 1'b0;
        repeat (3) cyc();
        reset = 1'b0;
        cyc();

        // Reset state
        expect_sig("rst_pix_ready", 1, 32'd0);
        expect_sig("rst_irq", 2, 32'd0);
        expect_rd("rst_status", STATUS_ADDR, 32'h0000_0001);
        expect_rd("rst_ctrl", CTRL_ADDR, 32'h0);

        // RAM and unmapped space
        wr(32'h0000_0000, 32'h0BAD_F00D);
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        wr(32'h0000_03FC, 32'h1234_5678);
        wr(32'h0000_0400, 32'hFFFF_FFFF);   // just past RAM: ignored
        expect_rd("ram_0x10", 32'h0000_0010, 32'hDEAD_BEEF);
        expect_rd("ram_0x13_lsb_ignored", 32'h0000_0013, 32'hDEAD_BEEF);
        expect_rd("ram_last", 32'h0000_03FC, 32'h1234_5678);
        expect_rd("ram_0_no_alias", 32'h0000_0000, 32'h0BAD_F00D);
        expect_rd("past_ram", 32'h0000_0400, 32'h0);
        expect_rd("unmapped", 32'h0002_0000, 32'h0);

        // One packed word, irq timing, pop
        wr(CTRL_ADDR, 32'h3);
        expect_rd("ctrl_3", CTRL_ADDR, 32'h3);
        send_pix(8'h11); send_pix(8'h22); send_pix(8'h33); send_pix(8'h44);
        expect_sig("irq_lag_after_push", 2, 32'd0);
        expect_rd("pixel_word", PIXEL_ADDR, 32'h4433_2211);
        expect_sig("irq_after_push", 2, 32'd1);
        expect_rd("status_cnt1", STATUS_ADDR, 32'h0000_0008);
        wr(PIXEL_ADDR, 32'h0);
        expect_sig("irq_lag_after_pop", 2, 32'd1);
        expect_rd("status_after_pop", STATUS_ADDR, 32'h0000_0001);
        expect_sig("irq_after_pop", 2, 32'd0);
        expect_rd("pixel_empty", PIXEL_ADDR, 32'h0);
        wr(PIXEL_ADDR, 32'h0);              // pop when empty: ignored
        expect_rd("status_pop_empty", STATUS_ADDR, 32'h0000_0001);

        // Fill past capacity
        for (int i = 0; i < 68; i++) send_pix(8'(i));
        expect_sig("full_pix_ready", 1, 32'd0);
        expect_sig("full_irq", 2, 32'd1);
        expect_rd("status_full_ovf", STATUS_ADDR, 32'h0000_0086);
        expect_rd("full_head", PIXEL_ADDR, 32'h0302_0100);
        wr(CTRL_ADDR, 32'h5);
        expect_sig("flush_pix_ready", 1, 32'd1);
        expect_rd("status_flushed", STATUS_ADDR, 32'h0000_0001);
        expect_rd("ctrl_flush_reads0", CTRL_ADDR, 32'h1);

        // Frame realignment
        send_pix(8'hAA); send_pix(8'hBB);
        frame_start = 1'b1; cyc(); frame_start = 1'b0;
        send_pix(8'h01); send_pix(8'h02); send_pix(8'h03); send_pix(8'h04);
        expect_rd("frame_head", PIXEL_ADDR, 32'h0403_0201);
        expect_rd("frame_status", STATUS_ADDR, 32'h0001_0008);
        send_pix(8'hCC);
        frame_start = 1'b1; send_pix(8'h05); frame_start = 1'b0;
        send_pix(8'h06); send_pix(8'h07); send_pix(8'h08);
        expect_rd("frame2_status", STATUS_ADDR, 32'h0002_0010);
        wr(PIXEL_ADDR, 32'h0);
        expect_rd("frame_with_pixel", PIXEL_ADDR, 32'h0807_0605);

        // Simultaneous push and pop
        send_pix(8'h09); send_pix(8'h0A); send_pix(8'h0B);
        pix_valid = 1'b1; pix_data = 8'h0C; addr = PIXEL_ADDR; we = 1'b1;
        cyc();
        pix_valid = 1'b0; we = 1'b0;
        expect_rd("pushpop_status", STATUS_ADDR, 32'h0002_0008);
        expect_rd("pushpop_head", PIXEL_ADDR, 32'h0C0B_0A09);

        // Capture disabled mid-word
        wr(PIXEL_ADDR, 32'h0);
        send_pix(8'h21); send_pix(8'h22);
        wr(CTRL_ADDR, 32'h0);
        expect_sig("capoff_pix_ready", 1, 32'd0);
        send_pix(8'h99);
        expect_rd("capoff_status", STATUS_ADDR, 32'h0002_0001);
        wr(CTRL_ADDR, 32'h1);
        send_pix(8'h23); send_pix(8'h24);
        expect_rd("resume_head", PIXEL_ADDR, 32'h2423_2221);
        expect_rd("resume_status", STATUS_ADDR, 32'h0002_0008);

        // Reset mid-stream
        wr(CTRL_ADDR, 32'h7);
        for (int i = 0; i < 14; i++) send_pix(8'(8'h40 + i));
        expect_sig("pre_rst_irq", 2, 32'd1);
        expect_rd("pre_rst_status", STATUS_ADDR, 32'h0002_0018);
        reset = 1'b1;
        expect_sig("mid_rst_pix_ready", 1, 32'd0);
        expect_sig("mid_rst_irq", 2, 32'd0);
        expect_rd("mid_rst_status", STATUS_ADDR, 32'h0000_0001);
        expect_rd("mid_rst_ctrl", CTRL_ADDR, 32'h0);
        reset = 1'b0;
        cyc();
        expect_rd("ram_survives_rst", 32'h0000_0010, 32'hDEAD_BEEF);
        wr(CTRL_ADDR, 32'h1);
        send_pix(8'h31); send_pix(8'h32); send_pix(8'h33); send_pix(8'h34);
        expect_rd("post_rst_head", PIXEL_ADDR, 32'h3433_3231);
        expect_rd("post_rst_status", STATUS_ADDR, 32'h0000_0008);

        cyc();
        for (int i = 0; i < 10 && nm_q.size() > 0; i++) begin
            chk_vld = 1'b1;
            cyc();
        end
        if (nm_q.size() > 0) begin
            $display("FAIL scoreboard_drain: actual %0d pending required 0", nm_q.size());
            n_bad += nm_q.size();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cam_mmio_bridge.md
Name: cam_mmio_bridge

Overview:
Data-side memory bridge sitting directly downstream of the ARM core's memory-stage outputs (ALUResult, WriteData, write_enable); it returns ReadData to the core. Decodes the address into a word data RAM and a camera capture block. Camera pixels are packed four per 32-bit word into a FIFO that software polls and pops through memory-mapped registers.

Parameters:
RAM_WORDS, 256, depth of data RAM in 32-bit words (power of 2)
FIFO_DEPTH, 16, depth of packed-pixel FIFO in words (power of 2, >=2)
PIXEL_W, 8, camera pixel width; four pixels per word (PIXEL_W*4 = 32)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
addr  in  32  byte address from core ALUResult
wdata  in  32  store data from core WriteData
we  in  1  store enable from core write_enable
rdata  out  32  load data to core ReadData (combinational)
pix_valid  in  1  camera pixel valid
pix_data  in  PIXEL_W  camera pixel
pix_ready  out  1  bridge accepts pixel this cycle
frame_start  in  1  one-cycle pulse at start of camera frame
irq  out  1  registered "data available" interrupt

Behaviour:
- Address map (addr[1:0] ignored): 0x0000_0000..RAM_WORDS*4-1 RAM; 0x0001_0000 STATUS (RO); 0x0001_0004 PIXEL (read = peek head word; write any value = pop); 0x0001_0008 CTRL (RW). All other addresses: read 0, writes ignored.
- RAM: asynchronous read, write on rising clk when we & RAM hit. Contents not reset.
- CTRL bits: [0] cap_en, [1] irq_en, [2] flush (write-1 action, reads 0). Flush empties FIFO, clears packer and overflow on that edge; flush beats a simultaneous push.
- STATUS: [0] empty, [1] full, [2] overflow (sticky), [3+:5] FIFO count, [15:8] reserved 0, [31:16] frame_cnt (wraps 0xFFFF->0).
- PIXEL read when empty returns 0. Pop when empty ignored.
- pix_ready = cap_en & ~full (combinational). Pixel accepted on edge when pix_valid & pix_ready.
- Packer: 2-bit index 0..3; accepted pixel i stored at bits [8i+7:8i]; on 4th accept the completed word pushes into FIFO same edge, index returns to 0.
- pix_valid & cap_en & full: pixel dropped, overflow set to 1.
- frame_start: packer index -> 0 (partial word discarded), frame_cnt += 1. frame_start with simultaneous accepted pixel: pixel becomes byte 0 of the new word.
- Simultaneous push and pop (not empty): both occur, count unchanged. Pop of full FIFO in same cycle never pushes (pix_ready already 0).
- cap_en cleared mid-word: packer holds partial word; resumes on re-enable.
- irq: registered, irq <= irq_en & ~empty (one-cycle lag after push/pop).
- Reset (async, mid-operation included): FIFO empty, count 0, packer index 0, ctrl 0, overflow 0, frame_cnt 0, irq 0; hence pix_ready 0. rdata follows addr combinationally (STATUS reads 0x0000_0001 after reset).

Decomposition:
- Package cam_mmio_pkg: address constants (RAM_BASE, STATUS_ADDR, PIXEL_ADDR, CTRL_ADDR), CTRL/STATUS bit-index localparams, region-select enum (REG_RAM, REG_STATUS, REG_PIXEL, REG_CTRL, REG_NONE).
- One sub-module: word_fifo (sync FIFO, WIDTH/DEPTH params, push/pop/flush, head, count, full, empty). Packer, decode and registers stay in top.

Test Plan:
- Reset then read 0x0001_0000 -> rdata 0x0000_0001; pix_ready 0; irq 0.
- Store 0xDEADBEEF to 0x10, load 0x10 -> 0xDEADBEEF; load 0x0002_0000 -> 0.
- Write CTRL=0x3, send pixels 0x11,0x22,0x33,0x44 -> PIXEL reads 0x44332211, STATUS count 1, irq 1 one cycle after push; write PIXEL -> empty, irq 0 next cycle.
- Enable capture, stream 4*FIFO_DEPTH+4 pixels without popping -> full=1, pix_ready 0, overflow=1, count 16; write CTRL=0x5 -> count 0, overflow 0.
- Send 0xAA,0xBB, pulse frame_start, send 0x01..0x04 -> head 0x04030201, frame_cnt 1.
- Assert reset mid-stream with FIFO count 3 -> all state cleared within the reset cycle, STATUS 0x0000_0001.
